limb_divider_seq: RTL

//  Sequential unsigned divider on 16-bit limbs: the inverse of the mul4 vector multiplier.

---
 rtl/limb_divider_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/limb_divider_seq.sv
// limb_divider_seq: sequential unsigned divider on LIMB_W-bit limbs.
// The 4-limb dividend is divided by the 2-limb divisor with a radix-2 restoring
// algorithm, one quotient bit per clock. The result registers hold their value
// until the next result is produced, so a consumer may stall indefinitely.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on state (high in IDLE). out_valid depends only on
// state (high in DONE). A source may raise valid at any time. Once out_valid is
// high, it and the result stay unchanged until out_ready is seen.
module limb_divider_seq #(
  parameter int LIMB_W  = 16,
  parameter bit DZ_QUOT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] d3,
  input  logic [LIMB_W-1:0] d2,
  input  logic [LIMB_W-1:0] d1,
  input  logic [LIMB_W-1:0] d0,
  input  logic [LIMB_W-1:0] b1,
  input  logic [LIMB_W-1:0] b0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] q3,
  output logic [LIMB_W-1:0] q2,
  output logic [LIMB_W-1:0] q1,
  output logic [LIMB_W-1:0] q0,
  output logic [LIMB_W-1:0] r1,
  output logic [LIMB_W-1:0] r0,
  output logic              div_zero,
  output logic [1:0]        dbg_state
);

  localparam int DW = 4 * LIMB_W;      // dividend / quotient width
  localparam int BW = 2 * LIMB_W;      // divisor / remainder width
  localparam int CW = $clog2(DW);      // bit counter width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [DW-1:0] r_dq;
  logic [BW-1:0] r_div;
  // The stored remainder always ends below the divisor, so BW bits suffice.
  // The BW+1-bit working value exists only as w_pr_shift.
  logic [BW-1:0] r_pr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q;
  logic [BW-1:0] r_r;
  logic          r_dz;

  logic [DW-1:0] w_dividend;
  logic [BW-1:0] w_divisor;
  logic          w_accept;
  logic          w_release;
  logic          w_busy;
  logic          w_last;
  logic          w_div_is_zero;
  logic [BW:0]   w_pr_shift;
  logic          w_ge;
  logic [BW-1:0] w_pr_next;
  logic [DW-1:0] w_dq_next;

  assign w_dividend    = {d3, d2, d1, d0};
  assign w_divisor     = {b1, b0};
  assign w_div_is_zero = (w_divisor == '0);
  assign w_accept      = in_valid && (r_state == S_IDLE);
  assign w_release     = out_ready && (r_state == S_DONE);
  assign w_busy        = (r_state == S_BUSY);
  assign w_last        = (r_cnt == CW'(DW - 1));

  // One restoring step. The compare needs BW+1 bits because the shifted
  // remainder can exceed an all-ones divisor. When the subtraction is taken,
  // the true difference is below 2^BW, so modular BW-bit subtraction is exact.
  assign w_pr_shift = {r_pr, r_dq[DW-1]};
  assign w_ge       = (w_pr_shift >= {1'b0, r_div});
  assign w_pr_next  = w_ge ? (w_pr_shift[BW-1:0] - r_div) : w_pr_shift[BW-1:0];
  assign w_dq_next  = {r_dq[DW-2:0], w_ge};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign dbg_state = r_state;

  assign {q3, q2, q1, q0} = r_q;
  assign {r1, r0}         = r_r;
  assign div_zero         = r_dz;

  // Control FSM: IDLE -> BUSY -> DONE -> IDLE, with a zero divisor skipping BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) r_state <= w_div_is_zero ? S_DONE : S_BUSY;
        S_BUSY: if (w_last) r_state <= S_DONE;
        S_DONE: if (w_release) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working registers: load operands on accept, then one shift/subtract per BUSY edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dq  <= '0;
      r_div <= '0;
      r_pr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_dq  <= w_dividend;
      r_div <= w_divisor;
      r_pr  <= '0;
      r_cnt <= '0;
    end else if (w_busy) begin
      r_dq  <= w_dq_next;
      r_pr  <= w_pr_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: written only when a result is produced, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      r_r  <= '0;
      r_dz <= 1'b0;
    end else if (w_accept && w_div_is_zero) begin
      r_q  <= DZ_QUOT ? {DW{1'b1}} : {DW{1'b0}};
      r_r  <= w_dividend[BW-1:0];
      r_dz <= 1'b1;
    end else if (w_busy && w_last) begin
      r_q  <= w_dq_next;
      r_r  <= w_pr_next;
      r_dz <= 1'b0;
    end
  end

endmodule
